// File: rtl/hazard_unit.sv
// hazard_unit: decode-stage interlock for the cpu32 pipeline with a saturating stall counter.
// Optional: define HAZARD_FORWARD_EN for bypass selects and load-use-only stalls.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic [3:0]       de_opcode,
  input  logic [3:0]       de_rd,
  input  logic [3:0]       de_ra,
  input  logic [3:0]       de_rb,
  input  logic             flush,
  output logic             hazard,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic reads_a(input logic [3:0] op);
    return (op <= 4'd7);
  endfunction

  function automatic logic reads_b(input logic [3:0] op);
    case (op)
      4'd0, 4'd3, 4'd6, 4'd7: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Stores carry their data register in rd, so it is compared as operand b.
  function automatic logic [3:0] src_b(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rb);
    return (op == 4'd3) ? rd : rb;
  endfunction

  function automatic logic writes(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] dest_of(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rb);
    return (op >= 4'd4 && op <= 4'd7) ? rb : rd;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

`ifdef HAZARD_FORWARD_EN
  function automatic logic is_load(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd8);
  endfunction

  function automatic logic [1:0] youngest(input logic in_ex, input logic in_mem,
                                          input logic in_wb);
    if (in_ex)       return 2'd1;
    else if (in_mem) return 2'd2;
    else if (in_wb)  return 2'd3;
    else             return 2'd0;
  endfunction
`endif

  logic       ex_vld_p0, mem_vld_p1, wb_vld_p2;
  logic [3:0] ex_dest_p0, mem_dest_p1, wb_dest_p2;
  logic       use_a, use_b;
  logic [3:0] opnd_b;
  logic       a_ex, a_mem, a_wb;
  logic       b_ex, b_mem, b_wb;
  logic       conflict;
  logic       issue;

  assign use_a  = reads_a(de_opcode);
  assign use_b  = reads_b(de_opcode);
  assign opnd_b = src_b(de_opcode, de_rd, de_rb);

  assign a_ex  = use_a & ex_vld_p0  & (ex_dest_p0  == de_ra);
  assign a_mem = use_a & mem_vld_p1 & (mem_dest_p1 == de_ra);
  assign a_wb  = use_a & wb_vld_p2  & (wb_dest_p2  == de_ra);
  assign b_ex  = use_b & ex_vld_p0  & (ex_dest_p0  == opnd_b);
  assign b_mem = use_b & mem_vld_p1 & (mem_dest_p1 == opnd_b);
  assign b_wb  = use_b & wb_vld_p2  & (wb_dest_p2  == opnd_b);

`ifdef HAZARD_FORWARD_EN
  logic ex_load_p0;

  // Only a load still in EX has no value to bypass yet.
  assign conflict = ex_load_p0 & (a_ex | b_ex);
  assign fwd_a    = de_valid ? youngest(a_ex, a_mem, a_wb) : 2'd0;
  assign fwd_b    = de_valid ? youngest(b_ex, b_mem, b_wb) : 2'd0;
`else
  // No regfile write-through, so a match anywhere down to WB must wait.
  assign conflict = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
  assign fwd_a    = 2'd0;
  assign fwd_b    = 2'd0;
`endif

  assign hazard = de_valid & ~flush & conflict;
  assign issue  = de_valid & writes(de_opcode) & ~hazard & ~flush;

  // Stage boundary: decode -> EX -> MEM -> WB tracking, never stalled below decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_vld_p0   <= 1'b0;
      ex_dest_p0  <= 4'd0;
      mem_vld_p1  <= 1'b0;
      mem_dest_p1 <= 4'd0;
      wb_vld_p2   <= 1'b0;
      wb_dest_p2  <= 4'd0;
    end else begin
      ex_vld_p0   <= issue;
      ex_dest_p0  <= issue ? dest_of(de_opcode, de_rd, de_rb) : 4'd0;
      mem_vld_p1  <= ex_vld_p0;
      mem_dest_p1 <= ex_dest_p0;
      wb_vld_p2   <= mem_vld_p1;
      wb_dest_p2  <= mem_dest_p1;
    end
  end

`ifdef HAZARD_FORWARD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_load_p0 <= 1'b0;
    else       ex_load_p0 <= issue & is_load(de_opcode);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       stall_count <= '0;
    else if (hazard) stall_count <= sat_inc(stall_count);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized decode traffic
// compared against an in-flight-list reference model.
module tb_hazard_unit;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             de_valid;
  logic [3:0]       de_opcode, de_rd, de_ra, de_rb;
  logic             flush;
  logic             hazard;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_opcode(de_opcode),
    .de_rd(de_rd), .de_ra(de_ra), .de_rb(de_rb), .flush(flush),
    .hazard(hazard), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight writers, youngest first (EX, MEM, WB).
  typedef struct {bit v; bit [3:0] d; bit ld;} ent_t;
  ent_t pipe[$];
  int   m_cnt;

  function automatic bit m_reads_a(bit [3:0] op);
    return op inside {[0:7]};
  endfunction
  function automatic bit m_reads_b(bit [3:0] op);
    return op inside {0, 3, 6, 7};
  endfunction
  function automatic bit [3:0] m_src_b();
    return (de_opcode == 3) ? de_rd : de_rb;
  endfunction
  function automatic bit m_writes(bit [3:0] op);
    return op inside {0, 1, 2, [4:7], 8};
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    if (!de_valid || flush) return 0;
    foreach (pipe[i]) begin
      bit blocks = pipe[i].v;
`ifdef HAZARD_FORWARD_EN
      blocks = blocks && (i == 0) && pipe[i].ld;
`endif
      if (blocks && m_reads_a(de_opcode) && pipe[i].d == de_ra) h = 1;
      if (blocks && m_reads_b(de_opcode) && pipe[i].d == m_src_b()) h = 1;
    end
    return h;
  endfunction

  function automatic bit [1:0] m_fwd(bit [3:0] src, bit used);
`ifdef HAZARD_FORWARD_EN
    if (!de_valid || !used) return 0;
    foreach (pipe[i]) if (pipe[i].v && pipe[i].d == src) return 2'(i + 1);
`endif
    return 0;
  endfunction

  task automatic m_clear();
    pipe = {};
    repeat (3) pipe.push_back('{0, 4'd0, 0});
    m_cnt = 0;
  endtask

  task automatic tick();
    bit   h;
    ent_t e;
    h = m_hazard();
    if (de_valid && m_writes(de_opcode) && !h && !flush)
      e = '{1, (de_opcode inside {[4:7]}) ? de_rb : de_rd, de_opcode inside {2, 8}};
    else
      e = '{0, 4'd0, 0};
    @(posedge clk);
    if (h && m_cnt < CNT_MAX) m_cnt++;
    pipe.push_front(e);
    void'(pipe.pop_back());
    #1;
  endtask

  task automatic drive(bit v, bit [3:0] op, bit [3:0] rd, bit [3:0] ra, bit [3:0] rb, bit fl);
    de_valid = v; de_opcode = op; de_rd = rd; de_ra = ra; de_rb = rb; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_clear();
    drive(0, 4'd14, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_clear();
    drive(1, 4'd0, 4'd1, 4'd1, 4'd1, 0);
    n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard got=%b want=0", hazard); else n_pass++;
    n_checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) $display("FAIL reset_fwd got=%0d/%0d want=0/0", fwd_a, fwd_b); else n_pass++;
    n_checks++; if (stall_count !== '0) $display("FAIL reset_count got=%0d want=0", stall_count); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

`ifndef HAZARD_FORWARD_EN
  task automatic test_raw_no_fwd();
    do_reset();
    drive(1, 4'd0, 4'd3, 4'd1, 4'd2, 0);
    n_checks++; if (hazard !== 1'b0) $display("FAIL raw_producer hazard got=%b want=0", hazard); else n_pass++;
    tick();
    drive(1, 4'd0, 4'd4, 4'd3, 4'd5, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (hazard !== 1'b1) $display("FAIL raw_stall%0d hazard got=%b want=1", i, hazard); else n_pass++;
      tick();
    end
    n_checks++; if (hazard !== 1'b0) $display("FAIL raw_release hazard got=%b want=0", hazard); else n_pass++;
    n_checks++; if (stall_count !== 4'd3) $display("FAIL raw_count got=%0d want=3", stall_count); else n_pass++;
    tick();
    drive(1, 4'd1, 4'd6, 4'd4, 4'd0, 0);
    n_checks++; if (hazard !== 1'b1) $display("FAIL raw_issued hazard got=%b want=1", hazard); else n_pass++;
  endtask
`endif

  task automatic test_store_data();
    do_reset();
    drive(1, 4'd2, 4'd7, 4'd1, 4'd0, 0);
    tick();
    drive(1, 4'd3, 4'd7, 4'd2, 4'd0, 0);
    n_checks++; if (hazard !== 1'b1) $display("FAIL store_rd hazard got=%b want=1", hazard); else n_pass++;
`ifdef HAZARD_FORWARD_EN
    n_checks++; if (fwd_b !== 2'd1) $display("FAIL store_fwd_b got=%0d want=1", fwd_b); else n_pass++;
`endif
    drive(1, 4'd3, 4'd0, 4'd2, 4'd7, 0);
    n_checks++; if (hazard !== 1'b0) $display("FAIL store_rb_ignored hazard got=%b want=0", hazard); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 4'd0, 4'd3, 4'd1, 4'd2, 0);
    tick();
    drive(1, 4'd0, 4'd9, 4'd3, 4'd5, 1);
    n_checks++; if (hazard !== 1'b0) $display("FAIL flush_override hazard got=%b want=0", hazard); else n_pass++;
    tick();
    drive(1, 4'd1, 4'd0, 4'd9, 4'd0, 0);
    n_checks++; if (hazard !== 1'b0 || fwd_a !== 2'd0) $display("FAIL flush_bubble hazard/fwd_a got=%b/%0d want=0/0", hazard, fwd_a); else n_pass++;
    drive(1, 4'd1, 4'd0, 4'd3, 4'd0, 0);
`ifdef HAZARD_FORWARD_EN
    n_checks++; if (hazard !== 1'b0 || fwd_a !== 2'd2) $display("FAIL flush_mem hazard/fwd_a got=%b/%0d want=0/2", hazard, fwd_a); else n_pass++;
`else
    n_checks++; if (hazard !== 1'b1) $display("FAIL flush_mem hazard got=%b want=1", hazard); else n_pass++;
`endif
    tick();
`ifdef HAZARD_FORWARD_EN
    n_checks++; if (fwd_a !== 2'd3) $display("FAIL flush_wb fwd_a got=%0d want=3", fwd_a); else n_pass++;
`else
    n_checks++; if (hazard !== 1'b1 || stall_count !== 4'd1) $display("FAIL flush_wb hazard/count got=%b/%0d want=1/1", hazard, stall_count); else n_pass++;
`endif
  endtask

`ifdef HAZARD_FORWARD_EN
  task automatic test_forward();
    do_reset();
    drive(1, 4'd0, 4'd3, 4'd1, 4'd2, 0);
    tick();
    drive(1, 4'd0, 4'd4, 4'd3, 4'd3, 0);
    n_checks++; if (hazard !== 1'b0) $display("FAIL fwd_alu hazard got=%b want=0", hazard); else n_pass++;
    n_checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) $display("FAIL fwd_alu_sel got=%0d/%0d want=1/1", fwd_a, fwd_b); else n_pass++;
    tick();
    drive(1, 4'd0, 4'd5, 4'd3, 4'd4, 0);
    n_checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd1) $display("FAIL fwd_mix_sel got=%0d/%0d want=2/1", fwd_a, fwd_b); else n_pass++;
    do_reset();
    drive(1, 4'd2, 4'd3, 4'd1, 4'd0, 0);
    tick();
    drive(1, 4'd0, 4'd4, 4'd3, 4'd3, 0);
    n_checks++; if (hazard !== 1'b1) $display("FAIL fwd_load_use hazard got=%b want=1", hazard); else n_pass++;
    tick();
    n_checks++; if (hazard !== 1'b0 || fwd_a !== 2'd2) $display("FAIL fwd_after_load hazard/fwd_a got=%b/%0d want=0/2", hazard, fwd_a); else n_pass++;
    n_checks++; if (stall_count !== 4'd1) $display("FAIL fwd_load_count got=%0d want=1", stall_count); else n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    drive(1, 4'd2, 4'd3, 4'd1, 4'd0, 0);
    tick();
    drive(1, 4'd1, 4'd0, 4'd3, 4'd0, 0);
    n_checks++; if (hazard !== 1'b1) $display("FAIL areset_pre hazard got=%b want=1", hazard); else n_pass++;
    tick();
    n_checks++; if (stall_count !== 4'd1) $display("FAIL areset_pre_count got=%0d want=1", stall_count); else n_pass++;
    #2;
    reset = 1'b1;
    m_clear();
    #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL areset_hazard got=%b want=0", hazard); else n_pass++;
    n_checks++; if (stall_count !== '0) $display("FAIL areset_count got=%0d want=0", stall_count); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 4'd2, 4'd3, 4'd3, 4'd0, 0);
    repeat (20) tick();
    n_checks++; if (stall_count !== 4'(m_cnt)) $display("FAIL sat_mid got=%0d want=%0d", stall_count, m_cnt); else n_pass++;
    repeat (40) tick();
    n_checks++; if (stall_count !== 4'd15) $display("FAIL sat_hold got=%0d want=15", stall_count); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      n_checks++; if (hazard !== m_hazard()) $display("FAIL rnd%0d hazard got=%b want=%b", i, hazard, m_hazard()); else n_pass++;
      n_checks++; if (fwd_a !== m_fwd(de_ra, m_reads_a(de_opcode))) $display("FAIL rnd%0d fwd_a got=%0d want=%0d", i, fwd_a, m_fwd(de_ra, m_reads_a(de_opcode))); else n_pass++;
      n_checks++; if (fwd_b !== m_fwd(m_src_b(), m_reads_b(de_opcode))) $display("FAIL rnd%0d fwd_b got=%0d want=%0d", i, fwd_b, m_fwd(m_src_b(), m_reads_b(de_opcode))); else n_pass++;
      n_checks++; if (stall_count !== 4'(m_cnt)) $display("FAIL rnd%0d count got=%0d want=%0d", i, stall_count, m_cnt); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
`ifndef HAZARD_FORWARD_EN
    test_raw_no_fwd();
`else
    test_forward();
`endif
    test_store_data();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Interlock unit for the cpu32 pipeline. It tracks the destination registers of instructions in flight in EX, MEM and WB. It compares them against the source registers of the instruction in decode and drives the `hazard` input of the control decoder. When `hazard` is high, control emits a NOP bubble and the fetch/decode registers hold. It also kills the decode instruction on a taken branch and counts stall cycles for performance monitoring.

## Interface
Parameters:
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `de_valid`  input  1  the decode stage holds a real instruction.
- `de_opcode`  input  4  opcode of the decode instruction.
- `de_rd`  input  4  rd field (opd).
- `de_ra`  input  4  ra field.
- `de_rb`  input  4  rb field (opb).
- `flush`  input  1  taken branch; the decode instruction is discarded this cycle.
- `hazard`  output  1  to control `hazard`; also the hold enable for the PC and decode registers.
- `fwd_a`  output  2  adata source: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB. Driven only with `FORWARD_EN`; otherwise tied to 0.
- `fwd_b`  output  2  bdata/store-data source; same encoding as `fwd_a`.
- `stall_count`  output  `CNT_W`  saturating count of cycles with `hazard` high.

## Operation
Source use by opcode (`reads_a`, `reads_b` define the compared fields):
- 0 ALU reg: ra, rb.
- 1 ALU imm: ra.
- 2 LW: ra.
- 3 SW: ra, plus rd as store data (treated as operand b).
- 4/5 BL rel16: ra.
- 6/7 BL Rb: ra, rb.
- 8 LW PC-relative, 14 NOP, and all others: none.

Destination by opcode:
- 0, 1, 2, 8 write rd.
- 4–7 write the link register to rb.
- 3, 14 and all others write nothing.
- Register 0 is not special-cased.

Tracking state:
- Three entries, EX, MEM and WB, each holding `{valid, dest[3:0], is_load}`. `is_load` is set for opcodes 2 and 8.
- Every cycle MEM ← EX and WB ← MEM. There is no stall below decode.
- EX ← `{1, dest, is_load}` when `de_valid & writes & !hazard & !flush`. Otherwise EX ← `{0, 0, 0}` (bubble).

Match rule: source X matches entry E when `E.valid` is set and `E.dest == X`, for a source the opcode reads.

Hazard rule without `FORWARD_EN`:
- `hazard = de_valid & !flush & (any read source matches EX, MEM or WB)`.
- The regfile has no write-through, so a WB match stalls.

Flush:
- `flush` overrides everything: `hazard` = 0 and EX gets a bubble.
- The tracked older entries still advance.

Counter:
- `stall_count` increments on each edge where `hazard` = 1.
- It saturates at all-ones and never wraps.

## Timing
- `hazard`, `fwd_a`, `fwd_b` are combinational from the decode inputs and registered entries, valid in the same cycle.
- Reset asserted: all entries cleared, so `hazard` = 0 and `fwd_*` = 0; `stall_count` = 0.
- Reset mid-operation discards all in-flight tracking immediately, without waiting for a clock.
- Back-to-back dependent ALU ops without forwarding give 3 stall cycles: the producer moves EX, MEM, WB, and the consumer issues once WB retires.
- Simultaneous matches in several stages select the youngest for forwarding: EX beats MEM beats WB.
- `de_valid` = 0 yields `hazard` = 0 regardless of fields.

## Configuration
- Macro: `HAZARD_FORWARD_EN`.
- Defined:
  - `fwd_a`/`fwd_b` select the youngest matching stage.
  - `hazard` is raised only on a load-use conflict, i.e. a read source matches EX with `EX.is_load`.
  - When stalled, `fwd_*` still reflect matches; the consumer re-evaluates next cycle.
  - On a load-use stall the bubble enters EX, and the next cycle forwards from MEM (value 2).
- Undefined:
  - `fwd_*` are constant 0.
  - `hazard` uses the full EX/MEM/WB match rule.

## Test plan
- Reset during a stall (EX holds dest r3, decode reads r3, `hazard` = 1): assert `reset` mid-cycle → `hazard` drops to 0 without a clock edge; `stall_count` = 0.
- No-forward RAW: issue `ALU r3,r1,r2` then `ALU r4,r3,r5` → `hazard` high for exactly 3 cycles, consumer issues on the 4th; `stall_count` = 3.
- Store data dependency: `LW r7,[r1,#0]` then `SW r7,[r2,#4]` → stall detected via the rd→operand-b path.
- Flush overriding a stall: dependent instruction in decode with `flush` = 1 → `hazard` = 0, EX becomes a bubble, MEM/WB still advance.
- FORWARD_EN: `ALU r3,…` then `ALU r4,r3,r3` → `hazard` = 0, `fwd_a` = `fwd_b` = 1. With `LW r3` as the producer: 1 stall cycle, then `fwd_a` = 2.
- Saturation: with `CNT_W` = 4, hold a stall for 20 cycles → `stall_count` stops at 15.
